// File: rtl/dmem_bridge_pkg.sv
// Shared types and constants for the data-memory bus bridge.
// The optional posted-write buffer is enabled with the POSTED_WRITE_EN macro.
package dmem_bridge_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

    localparam logic [DATA_W-1:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

    // Bridge transaction states: idle, request outstanding, one-cycle completion
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // One posted store as held in the write buffer
    typedef struct packed {
        logic [BE_W-1:0]   be;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wbuf_entry_t;

    // CPU word address to bus byte address (top two word-address bits fall off)
    function automatic logic [ADDR_W-1:0] word_to_byte_addr(input logic [ADDR_W-1:0] word_addr);
        return {word_addr[ADDR_W-3:0], 2'b00};
    endfunction

endpackage

// File: rtl/dmem_wbuf.sv
// Posted-write FIFO for the data-memory bridge; only built with POSTED_WRITE_EN.
// Pointers carry an extra wrap bit so full and empty are distinguishable.
`ifdef POSTED_WRITE_EN
module dmem_wbuf
    import dmem_bridge_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  logic        pop,
    input  wbuf_entry_t din,
    output wbuf_entry_t dout,
    output logic        full,
    output logic        empty
);

    localparam int AW = $clog2(DEPTH);

    wbuf_entry_t     mem_q [DEPTH];
    logic [AW:0]     wr_ptr_q, wr_ptr_d;
    logic [AW:0]     rd_ptr_q, rd_ptr_d;
    logic            do_push, do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign dout    = mem_q[rd_ptr_q[AW-1:0]];

    // Advance each pointer when its side of the FIFO moves
    always_comb begin
        wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
        rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
    end

    // Pointer registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array needs no reset; only slots between the pointers are ever read
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

endmodule
`endif

// File: rtl/dmem_bus_bridge.sv
// Data-memory bridge: turns CPU per-cycle byte-lane accesses into req/ack bus
// transactions, stalls the CPU through cpu_ready, and aborts hung requests.
// Define POSTED_WRITE_EN to post stores through a WBUF_DEPTH-entry FIFO.
module dmem_bus_bridge
    import dmem_bridge_pkg::*;
#(
    parameter int                TIMEOUT    = 64,
    parameter logic [DATA_W-1:0] ERR_DATA   = ERR_DATA_DEFAULT
`ifdef POSTED_WRITE_EN
    ,
    parameter int                WBUF_DEPTH = 4
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_rd,
    input  logic [BE_W-1:0]   cpu_wea,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    output logic              bus_req,
    output logic              bus_we,
    output logic [BE_W-1:0]   bus_be,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_ack,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              bus_err
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              bus_req_q, bus_req_d;
    logic              bus_we_q, bus_we_d;
    logic [BE_W-1:0]   bus_be_q, bus_be_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic              bus_err_q, bus_err_d;
    logic              wr_req, rd_req, timeout_hit;
    logic              unused_addr_bits;

    assign wr_req           = |cpu_wea;
    assign rd_req           = cpu_rd && !wr_req;
    assign timeout_hit      = (TIMEOUT > 0) && (cnt_q == CNT_W'(TIMEOUT - 1));
    assign unused_addr_bits = ^cpu_addr[ADDR_W-1:ADDR_W-2];

`ifdef POSTED_WRITE_EN
    logic        wbuf_push, wbuf_pop, wbuf_full, wbuf_empty;
    wbuf_entry_t wbuf_in, wbuf_head;

    assign wbuf_in = '{be: cpu_wea, addr: word_to_byte_addr(cpu_addr), data: cpu_wdata};

    dmem_wbuf #(
        .DEPTH (WBUF_DEPTH)
    ) u_wbuf (
        .clk   (clk),
        .reset (reset),
        .push  (wbuf_push),
        .pop   (wbuf_pop),
        .din   (wbuf_in),
        .dout  (wbuf_head),
        .full  (wbuf_full),
        .empty (wbuf_empty)
    );
`endif

    // Transaction FSM: next state, registered bus fields and CPU handshake
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_be_d    = bus_be_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        bus_err_d   = bus_err_q;
        cpu_ready   = 1'b0;
`ifdef POSTED_WRITE_EN
        wbuf_push   = wr_req && !wbuf_full;
        wbuf_pop    = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
`ifdef POSTED_WRITE_EN
                // Stores complete on entering the buffer; loads wait until it is drained
                cpu_ready = wr_req ? !wbuf_full : !rd_req;
                if (!wbuf_empty) begin
                    bus_req_d   = 1'b1;
                    bus_we_d    = 1'b1;
                    bus_be_d    = wbuf_head.be;
                    bus_addr_d  = wbuf_head.addr;
                    bus_wdata_d = wbuf_head.data;
                    cnt_d       = '0;
                    state_d     = ST_BUS;
                end else if (rd_req) begin
                    bus_req_d   = 1'b1;
                    bus_we_d    = 1'b0;
                    bus_be_d    = '1;
                    bus_addr_d  = word_to_byte_addr(cpu_addr);
                    bus_wdata_d = cpu_wdata;
                    cnt_d       = '0;
                    state_d     = ST_BUS;
                end
`else
                cpu_ready = !(wr_req || rd_req);
                if (wr_req || rd_req) begin
                    bus_req_d   = 1'b1;
                    bus_we_d    = wr_req;
                    bus_be_d    = wr_req ? cpu_wea : '1;
                    bus_addr_d  = word_to_byte_addr(cpu_addr);
                    bus_wdata_d = cpu_wdata;
                    cnt_d       = '0;
                    state_d     = ST_BUS;
                end
`endif
            end
            ST_BUS: begin
`ifdef POSTED_WRITE_EN
                cpu_ready = wr_req ? !wbuf_full : !rd_req;
`endif
                if (bus_ack || timeout_hit) begin
                    bus_req_d = 1'b0;
                    state_d   = ST_RESP;
                    if (!bus_we_q) begin
                        cpu_rdata_d = bus_ack ? bus_rdata : ERR_DATA;
                    end
                    if (!bus_ack) begin
                        bus_err_d = 1'b1;
                    end
`ifdef POSTED_WRITE_EN
                    wbuf_pop = bus_we_q;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
`ifdef POSTED_WRITE_EN
                cpu_ready = wr_req ? !wbuf_full : (rd_req ? !bus_we_q : 1'b1);
`else
                cpu_ready = 1'b1;
`endif
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and bus-field registers; reset drops any pending request immediately
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_be_q    <= '0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            cpu_rdata_q <= '0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_be_q    <= bus_be_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            bus_err_q   <= bus_err_d;
        end
    end

    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_be    = bus_be_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign cpu_rdata = cpu_rdata_q;
    assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// Bench for dmem_bus_bridge (blocking-store build) with an 8-cycle watchdog.
module tb_dmem_bus_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_rd;
    logic [3:0]  cpu_wea;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_ready;
    logic        bus_req;
    logic        bus_we;
    logic [3:0]  bus_be;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        bus_err;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        rd;
        logic [3:0]  wea;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          ack_delay;
        bit          no_ack;
        logic [31:0] rdata;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic        exp_we;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_stall;
        int          exp_req;
    } vec_t;

    vec_t vecs[6];
    vec_t clean_vec;

    always #5 clk = ~clk;

    dmem_bus_bridge #(
        .TIMEOUT  (8),
        .ERR_DATA (32'hDEADBEEF)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_rd    (cpu_rd),
        .cpu_wea   (cpu_wea),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ready (cpu_ready),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_be    (bus_be),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_ack   (bus_ack),
        .bus_rdata (bus_rdata),
        .bus_err   (bus_err)
    );

    function automatic vec_t make_vec(input logic rd, input logic [3:0] wea, input logic [31:0] addr,
                                      input logic [31:0] wdata, input int ack_delay, input bit no_ack,
                                      input logic [31:0] rdata, input logic [31:0] exp_addr,
                                      input logic [3:0] exp_be, input logic exp_we,
                                      input logic [31:0] exp_rdata, input logic exp_err,
                                      input int exp_stall, input int exp_req);
        vec_t v;
        v.rd = rd; v.wea = wea; v.addr = addr; v.wdata = wdata;
        v.ack_delay = ack_delay; v.no_ack = no_ack; v.rdata = rdata;
        v.exp_addr = exp_addr; v.exp_be = exp_be; v.exp_we = exp_we;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err;
        v.exp_stall = exp_stall; v.exp_req = exp_req;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", name, actual, expected);
        end
    endtask

    // Issue one CPU access, play the bus side, and check the completed transaction
    task automatic applyStimulus(input vec_t v, input string tag);
        int          stall;
        int          req_cycles;
        bit          done;
        logic [31:0] seen_addr;
        logic [31:0] seen_wdata;
        logic [3:0]  seen_be;
        logic        seen_we;
        seen_addr = '0; seen_wdata = '0; seen_be = '0; seen_we = 1'b0;
        @(negedge clk);
        cpu_rd    = v.rd;
        cpu_wea   = v.wea;
        cpu_addr  = v.addr;
        cpu_wdata = v.wdata;
        #1;
        checkOutput({tag, ".ready_c0"}, 32'(cpu_ready), 32'd0);
        stall      = 1;
        req_cycles = 0;
        done       = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            bus_ack = 1'b0;
            if (cpu_ready) begin
                done = 1'b1;
            end else begin
                stall++;
                if (bus_req) begin
                    seen_addr  = bus_addr;
                    seen_wdata = bus_wdata;
                    seen_be    = bus_be;
                    seen_we    = bus_we;
                    if (!v.no_ack && req_cycles == v.ack_delay) begin
                        bus_ack   = 1'b1;
                        bus_rdata = v.rdata;
                    end else begin
                        bus_rdata = ~v.rdata;
                    end
                    req_cycles++;
                end
            end
        end
        bus_ack = 1'b0;
        checkOutput({tag, ".ready_seen"}, 32'(done), 32'd1);
        checkOutput({tag, ".stall"}, 32'(stall), 32'(v.exp_stall));
        checkOutput({tag, ".req_cycles"}, 32'(req_cycles), 32'(v.exp_req));
        checkOutput({tag, ".bus_addr"}, seen_addr, v.exp_addr);
        checkOutput({tag, ".bus_be"}, 32'(seen_be), 32'(v.exp_be));
        checkOutput({tag, ".bus_we"}, 32'(seen_we), 32'(v.exp_we));
        if (v.exp_we) begin
            checkOutput({tag, ".bus_wdata"}, seen_wdata, v.wdata);
        end
        checkOutput({tag, ".req_dropped"}, 32'(bus_req), 32'd0);
        checkOutput({tag, ".cpu_rdata"}, cpu_rdata, v.exp_rdata);
        checkOutput({tag, ".bus_err"}, 32'(bus_err), 32'(v.exp_err));
        cpu_rd  = 1'b0;
        cpu_wea = 4'b0000;
        @(negedge clk);
        checkOutput({tag, ".idle_ready"}, 32'(cpu_ready), 32'd1);
        checkOutput({tag, ".idle_req"}, 32'(bus_req), 32'd0);
    endtask

    // Hard stop in case the sequence never reaches its summary
    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: actual=running required=finished");
        $fatal(1, "[TB] simulation time limit exceeded");
    end

    // Main sequence: reset values, stray ack, vector table, mid-transaction reset
    initial begin
        //              rd    wea      addr          wdata         dly nack rdata         exp_addr      be       we    exp_rdata     err  stall req
        vecs[0] = make_vec(1'b1, 4'b0000, 32'h00000040, 32'h00000000, 3, 0, 32'h12345678, 32'h00000100, 4'b1111, 1'b0, 32'h12345678, 1'b0, 5, 4);
        vecs[1] = make_vec(1'b0, 4'b0100, 32'h00000010, 32'h00AB0000, 0, 0, 32'hFFFFFFFF, 32'h00000040, 4'b0100, 1'b1, 32'h12345678, 1'b0, 2, 1);
        vecs[2] = make_vec(1'b1, 4'b0000, 32'hC0000001, 32'h00000000, 7, 0, 32'hCAFEF00D, 32'h00000004, 4'b1111, 1'b0, 32'hCAFEF00D, 1'b0, 9, 8);
        vecs[3] = make_vec(1'b1, 4'b1111, 32'h00000002, 32'h01020304, 1, 0, 32'h00000000, 32'h00000008, 4'b1111, 1'b1, 32'hCAFEF00D, 1'b0, 3, 2);
        vecs[4] = make_vec(1'b1, 4'b0000, 32'h00000080, 32'h00000000, 0, 1, 32'h00000000, 32'h00000200, 4'b1111, 1'b0, 32'hDEADBEEF, 1'b1, 9, 8);
        vecs[5] = make_vec(1'b1, 4'b0000, 32'h00000005, 32'h00000000, 0, 0, 32'h55AA55AA, 32'h00000014, 4'b1111, 1'b0, 32'h55AA55AA, 1'b1, 2, 1);
        clean_vec = make_vec(1'b1, 4'b0000, 32'h00000007, 32'h00000000, 2, 0, 32'h0BADF00D, 32'h0000001C, 4'b1111, 1'b0, 32'h0BADF00D, 1'b0, 4, 3);

        reset     = 1'b0;
        cpu_rd    = 1'b0;
        cpu_wea   = 4'b0000;
        cpu_addr  = '0;
        cpu_wdata = '0;
        bus_ack   = 1'b0;
        bus_rdata = '0;
        #1;
        checkOutput("rst.bus_req", 32'(bus_req), 32'd0);
        checkOutput("rst.bus_we", 32'(bus_we), 32'd0);
        checkOutput("rst.bus_be", 32'(bus_be), 32'd0);
        checkOutput("rst.bus_addr", bus_addr, 32'd0);
        checkOutput("rst.bus_wdata", bus_wdata, 32'd0);
        checkOutput("rst.cpu_rdata", cpu_rdata, 32'd0);
        checkOutput("rst.bus_err", 32'(bus_err), 32'd0);
        checkOutput("rst.cpu_ready", 32'(cpu_ready), 32'd1);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Stray ack with no access outstanding must be ignored
        @(negedge clk);
        bus_ack   = 1'b1;
        bus_rdata = 32'h99999999;
        repeat (3) @(negedge clk);
        checkOutput("stray.bus_req", 32'(bus_req), 32'd0);
        checkOutput("stray.cpu_rdata", cpu_rdata, 32'd0);
        checkOutput("stray.cpu_ready", 32'(cpu_ready), 32'd1);
        bus_ack = 1'b0;

        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset asserted between edges while a request is outstanding
        @(negedge clk);
        cpu_rd   = 1'b1;
        cpu_addr = 32'h00000007;
        @(negedge clk);
        checkOutput("midrst.pre_req", 32'(bus_req), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("midrst.bus_req", 32'(bus_req), 32'd0);
        checkOutput("midrst.bus_addr", bus_addr, 32'd0);
        checkOutput("midrst.bus_be", 32'(bus_be), 32'd0);
        checkOutput("midrst.bus_err", 32'(bus_err), 32'd0);
        checkOutput("midrst.cpu_rdata", cpu_rdata, 32'd0);
        cpu_rd = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(clean_vec, "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
